// File: rtl/fas_pkg.sv
// Shared types and constants for the FAS sample source.
// State enum, default sample/result widths, result counter width.
package fas_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam int DATA_W_DEF = 16;
  localparam int FREQ_W_DEF = 4;
  localparam int CNT_W      = 16;

endpackage

// File: rtl/fas_freq_capture.sv
// Captures FAS done/freq results into registered outputs.
// Ports: clk, rst, en_i (capture enable), clear_i (zero count),
//   done_i, freq_i -> freq_valid_o, freq_o, cnt_o (saturating).
module fas_freq_capture
  import fas_pkg::*;
#(
  parameter int FREQ_W = FREQ_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              clear_i,
  input  logic              done_i,
  input  logic [FREQ_W-1:0] freq_i,
  output logic              freq_valid_o,
  output logic [FREQ_W-1:0] freq_o,
  output logic [CNT_W-1:0]  cnt_o
);

  logic              cap;
  logic              fv_q, fv_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    cap    = en_i && done_i;
    fv_d   = cap;
    freq_d = cap ? freq_i : freq_q;
    cnt_d  = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (cap && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fv_q   <= 1'b0;
      freq_q <= '0;
      cnt_q  <= '0;
    end else begin
      fv_q   <= fv_d;
      freq_q <= freq_d;
      cnt_q  <= cnt_d;
    end
  end

  assign freq_valid_o = fv_q;
  assign freq_o       = freq_q;
  assign cnt_o        = cnt_q;

endmodule

// File: rtl/fas_sample_source.sv
// Streams samples from a 1-cycle-latency memory to FAS; captures results.
// Ports: clk, rst, start/stop/pause controls, mem_en/mem_addr/mem_rdata,
//   data_valid/data to FAS, done_in/freq_in from FAS,
//   freq_valid/freq_out/result_cnt, busy, finished.
// Build option: FAS_SRC_LOOP_EN makes the read pointer wrap forever.
module fas_sample_source
  import fas_pkg::*;
#(
  parameter int NUM_SAMPLES = 1000,
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int FREQ_W      = FREQ_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              data_valid,
  output logic [DATA_W-1:0] data,
  input  logic              done_in,
  input  logic [FREQ_W-1:0] freq_in,
  output logic              freq_valid,
  output logic [FREQ_W-1:0] freq_out,
  output logic [CNT_W-1:0]  result_cnt,
  output logic              busy,
  output logic              finished
);

  // One extra bit so the pointer can hold NUM_SAMPLES itself.
  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] PTR_END  = PTR_W'(NUM_SAMPLES);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_SAMPLES - 1);

`ifdef FAS_SRC_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              rd_flag_q, rd_flag_d;
  logic              dv_q, dv_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              accept;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    accept  = 1'b0;
    mem_en  = (state_q == STREAM) && !pause
              && (ptr_q < PTR_END);
    if (mem_en)
      ptr_d = (LOOP_EN && (ptr_q == PTR_LAST))
              ? '0 : ptr_q + PTR_W'(1);
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = STREAM;
          ptr_d   = '0;
          accept  = 1'b1;
        end
      end
      STREAM: begin
        if (stop) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else if (!LOOP_EN && (ptr_q == PTR_END)
                     && !rd_flag_q) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        if (stop) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else if (start) begin
          state_d = STREAM;
          ptr_d   = '0;
          accept  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
    // stop discards the read in flight; data keeps its last value.
    rd_flag_d = mem_en && !stop;
    dv_d      = rd_flag_q && !stop;
    data_d    = dv_d ? mem_rdata : data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      rd_flag_q <= 1'b0;
      dv_q      <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rd_flag_q <= rd_flag_d;
      dv_q      <= dv_d;
      data_q    <= data_d;
    end
  end

  assign mem_addr   = ptr_q[ADDR_W-1:0];
  assign data_valid = dv_q;
  assign data       = data_q;
  assign busy       = (state_q == STREAM);
  assign finished   = (state_q == FINISH);

  fas_freq_capture #(
    .FREQ_W(FREQ_W)
  ) u_cap (
    .clk         (clk),
    .rst         (rst),
    .en_i        (state_q != IDLE),
    .clear_i     (accept),
    .done_i      (done_in),
    .freq_i      (freq_in),
    .freq_valid_o(freq_valid),
    .freq_o      (freq_out),
    .cnt_o       (result_cnt)
  );

endmodule
